mac_unit_vert_pipe: RTL and testbench

MAC_UNIT_VERT_PIPE -- requirements
Module: mac_unit_vert_pipe

---
 rtl/mac_unit_vert_pipe_if.sv | 43 ++++
 rtl/mac_unit_vert_pipe.sv | 176 +++++++++++++++++
 tb/tb_mac_unit_vert_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_unit_vert_pipe_if.sv
// Column-beat bus for mac_unit_vert_pipe: activation/control beat in, group result out.
// The master side drives beats and consumes results; the slave side is the MAC.
interface mac_unit_vert_pipe_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int NUM_SEL       = VEC_LENGTH / 2,
    parameter int SEL_WIDTH     = $clog2(VEC_LENGTH) + 1,
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH,
    parameter int COL_WIDTH     = $clog2(DATA_WIDTH),
    parameter int ACC_WIDTH     = DATA_WIDTH + 17
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_last;
    logic signed [DATA_WIDTH-1:0]    act [VEC_LENGTH];
    logic        [SEL_WIDTH-1:0]     act_sel [NUM_SEL];
    logic signed [SUM_ACT_WIDTH-1:0] sum_act;
    logic        [COL_WIDTH-1:0]     column_idx;
    logic                            is_msb;
    logic                            is_skip_zero;
    logic        [SEL_WIDTH-1:0]     hamming_sel;
    logic                            hamming_sign;
    logic        [2:0]               mul_const;
    logic                            is_shift_mul;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [ACC_WIDTH-1:0]     result;
    logic                            overflow;

    modport master (
        output in_valid, in_last, act, act_sel, sum_act, column_idx, is_msb,
               is_skip_zero, hamming_sel, hamming_sign, mul_const, is_shift_mul,
               out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, in_last, act, act_sel, sum_act, column_idx, is_msb,
               is_skip_zero, hamming_sel, hamming_sign, mul_const, is_shift_mul,
               out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/mac_unit_vert_pipe.sv
// Two-stage column MAC: stage 1 registers selected activations and controls,
// stage 2 forms the column total and accumulates it over a group of columns.
module mac_unit_vert_pipe #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 8,
    parameter int NUM_SEL       = VEC_LENGTH / 2,
    parameter int SEL_WIDTH     = $clog2(VEC_LENGTH) + 1,
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH,
    parameter int COL_WIDTH     = $clog2(DATA_WIDTH),
    parameter int ACC_WIDTH     = DATA_WIDTH + 17
) (
    input logic clk,
    input logic reset,
    mac_unit_vert_pipe_if.slave bus
);
    localparam int TW = SUM_ACT_WIDTH + DATA_WIDTH;
    localparam int IW = $clog2(VEC_LENGTH);
    localparam logic [SEL_WIDTH-1:0] VL_SEL = SEL_WIDTH'(VEC_LENGTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    // Stage-1 registers
    logic                            s1_valid_reg;
    logic                            s1_last_reg;
    logic signed [DATA_WIDTH-1:0]    s1_act_reg [NUM_SEL];
    logic signed [DATA_WIDTH-1:0]    s1_ham_reg;
    logic signed [SUM_ACT_WIDTH-1:0] s1_sum_reg;
    logic        [COL_WIDTH-1:0]     s1_col_reg;
    logic                            s1_msb_reg;
    logic                            s1_skip_reg;
    logic                            s1_ham_sign_reg;
    logic        [2:0]               s1_mul_reg;
    logic                            s1_shift_reg;

    // Stage-2 / group state
    state_t                          state_reg;
    logic signed [ACC_WIDTH-1:0]     acc_reg;
    logic                            grp_ovf_reg;
    logic signed [ACC_WIDTH-1:0]     result_reg;
    logic                            overflow_reg;
    logic                            out_valid_reg;

    logic signed [DATA_WIDTH-1:0]    sel_act [NUM_SEL];
    logic signed [DATA_WIDTH-1:0]    ham_act;
    logic                            stall;
    logic                            accept;
    logic                            s2_fire;

    // Out-of-range selects read as zero so a select of VEC_LENGTH disables a slot.
    generate
        for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_sel
            assign sel_act[gi] = (bus.act_sel[gi] < VL_SEL) ?
                                 bus.act[bus.act_sel[gi][IW-1:0]] : '0;
        end
    endgenerate

    assign ham_act = (bus.hamming_sel < VL_SEL) ? bus.act[bus.hamming_sel[IW-1:0]] : '0;

    // Only a completing beat can collide with an unconsumed result.
    assign stall        = s1_valid_reg & s1_last_reg & out_valid_reg & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign accept       = bus.in_valid & ~stall;
    assign s2_fire      = s1_valid_reg & ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
        end else if (!stall) begin
            s1_valid_reg <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                s1_act_reg[i] <= sel_act[i];
            end
            s1_last_reg     <= bus.in_last;
            s1_ham_reg      <= ham_act;
            s1_sum_reg      <= bus.sum_act;
            s1_col_reg      <= bus.column_idx;
            s1_msb_reg      <= bus.is_msb;
            s1_skip_reg     <= bus.is_skip_zero;
            s1_ham_sign_reg <= bus.hamming_sign;
            s1_mul_reg      <= bus.mul_const;
            s1_shift_reg    <= bus.is_shift_mul;
        end
    end

    // Stage-2 column total
    logic signed [SUM_ACT_WIDTH-1:0] p_sum;
    logic signed [SUM_ACT_WIDTH-1:0] base;
    logic signed [TW-1:0]            prod;
    logic signed [TW-1:0]            ham_ext;
    logic signed [TW-1:0]            col_total;
    logic signed [ACC_WIDTH-1:0]     t_acc;
    logic signed [ACC_WIDTH-1:0]     acc_sum;
    logic                            add_ovf;

    always_comb begin
        p_sum = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            p_sum = p_sum + SUM_ACT_WIDTH'(s1_act_reg[i]);
        end
        base = p_sum;
        case ({s1_msb_reg, s1_skip_reg})
            2'b00:   base = s1_sum_reg - p_sum;
            2'b01:   base = p_sum;
            2'b10:   base = p_sum - s1_sum_reg;
            default: base = -p_sum;
        endcase
        prod = TW'($signed({1'b0, s1_mul_reg})) * TW'(s1_sum_reg);
        if (s1_shift_reg) begin
            prod = prod <<< 3;
        end
        ham_ext = TW'(s1_ham_reg);
        if (s1_ham_sign_reg) begin
            ham_ext = -ham_ext;
        end
        col_total = (TW'(base) <<< s1_col_reg) + prod + (ham_ext <<< s1_col_reg);
    end

    generate
        if (ACC_WIDTH >= TW) begin : g_ext
            assign t_acc = ACC_WIDTH'(col_total);
        end else begin : g_trunc
            assign t_acc = col_total[ACC_WIDTH-1:0];
        end
    endgenerate

    assign acc_sum = acc_reg + t_acc;
    assign add_ovf = (acc_reg[ACC_WIDTH-1] == t_acc[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

    // A completion in the same cycle as a consume overrides the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            grp_ovf_reg   <= 1'b0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (s2_fire) begin
                if (state_reg == IDLE) begin
                    acc_reg     <= t_acc;
                    grp_ovf_reg <= 1'b0;
                    if (s1_last_reg) begin
                        result_reg    <= t_acc;
                        overflow_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg <= ACCUM;
                    end
                end else begin
                    acc_reg     <= acc_sum;
                    grp_ovf_reg <= grp_ovf_reg | add_ovf;
                    if (s1_last_reg) begin
                        result_reg    <= acc_sum;
                        overflow_reg  <= grp_ovf_reg | add_ovf;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_mac_unit_vert_pipe.sv
// Directed bench for mac_unit_vert_pipe: a default-width unit and a 14-bit
// accumulator unit receive identical beats; results are queued as delivered.
module tb_mac_unit_vert_pipe;
    localparam int DW   = 8;
    localparam int VL   = 8;
    localparam int NS   = 4;
    localparam int SW   = 4;
    localparam int SAW  = 11;
    localparam int CW   = 3;
    localparam int AW   = 25;
    localparam int AW14 = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  in_valid;
    logic                  in_last;
    logic signed [DW-1:0]  act [VL];
    logic        [SW-1:0]  act_sel [NS];
    logic signed [SAW-1:0] sum_act;
    logic        [CW-1:0]  column_idx;
    logic                  is_msb;
    logic                  is_skip_zero;
    logic        [SW-1:0]  hamming_sel;
    logic                  hamming_sign;
    logic        [2:0]     mul_const;
    logic                  is_shift_mul;
    logic                  out_ready;

    mac_unit_vert_pipe_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .NUM_SEL(NS), .SEL_WIDTH(SW),
        .SUM_ACT_WIDTH(SAW), .COL_WIDTH(CW), .ACC_WIDTH(AW)) ih ();
    mac_unit_vert_pipe_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .NUM_SEL(NS), .SEL_WIDTH(SW),
        .SUM_ACT_WIDTH(SAW), .COL_WIDTH(CW), .ACC_WIDTH(AW14)) ih14 ();

    assign ih.in_valid     = in_valid;     assign ih14.in_valid     = in_valid;
    assign ih.in_last      = in_last;      assign ih14.in_last      = in_last;
    assign ih.act          = act;          assign ih14.act          = act;
    assign ih.act_sel      = act_sel;      assign ih14.act_sel      = act_sel;
    assign ih.sum_act      = sum_act;      assign ih14.sum_act      = sum_act;
    assign ih.column_idx   = column_idx;   assign ih14.column_idx   = column_idx;
    assign ih.is_msb       = is_msb;       assign ih14.is_msb       = is_msb;
    assign ih.is_skip_zero = is_skip_zero; assign ih14.is_skip_zero = is_skip_zero;
    assign ih.hamming_sel  = hamming_sel;  assign ih14.hamming_sel  = hamming_sel;
    assign ih.hamming_sign = hamming_sign; assign ih14.hamming_sign = hamming_sign;
    assign ih.mul_const    = mul_const;    assign ih14.mul_const    = mul_const;
    assign ih.is_shift_mul = is_shift_mul; assign ih14.is_shift_mul = is_shift_mul;
    assign ih.out_ready    = out_ready;    assign ih14.out_ready    = out_ready;

    mac_unit_vert_pipe #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .NUM_SEL(NS), .SEL_WIDTH(SW),
        .SUM_ACT_WIDTH(SAW), .COL_WIDTH(CW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .bus(ih));
    mac_unit_vert_pipe #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .NUM_SEL(NS), .SEL_WIDTH(SW),
        .SUM_ACT_WIDTH(SAW), .COL_WIDTH(CW), .ACC_WIDTH(AW14)) dut14 (
        .clk(clk), .reset(reset), .bus(ih14));

    int errors = 0;
    int checks = 0;
    int q_res[$];
    bit q_ovf[$];
    int q14_res[$];
    bit q14_ovf[$];

    always @(posedge clk) begin
        if (ih.out_valid && ih.out_ready) begin
            q_res.push_back(int'(ih.result));
            q_ovf.push_back(ih.overflow);
            $display("t=%0t delivered result=%0d overflow=%0b", $time, ih.result, ih.overflow);
        end
        if (ih14.out_valid && ih14.out_ready) begin
            q14_res.push_back(int'(ih14.result));
            q14_ovf.push_back(ih14.overflow);
            $display("t=%0t delivered14 result=%0d overflow=%0b", $time, ih14.result, ih14.overflow);
        end
    end

    function automatic int res_at(input int i);
        return (i < q_res.size()) ? q_res[i] : 32'h7fff_ffff;
    endfunction
    function automatic int res14_at(input int i);
        return (i < q14_res.size()) ? q14_res[i] : 32'h7fff_ffff;
    endfunction
    function automatic int ovf_at(input int i);
        return (i < q_ovf.size()) ? int'(q_ovf[i]) : 7;
    endfunction
    function automatic int ovf14_at(input int i);
        return (i < q14_ovf.size()) ? int'(q14_ovf[i]) : 7;
    endfunction

    task automatic clear_q();
        q_res.delete(); q_ovf.delete(); q14_res.delete(); q14_ovf.delete();
    endtask

    task automatic set_act(input bit saturate);
        for (int i = 0; i < VL; i++) act[i] = saturate ? 8'sd127 : DW'(i + 1);
    endtask

    task automatic set_beat(input bit ms, input bit sz, input int sumv, input int col,
                            input int mulc, input bit shm, input int hsel, input bit hsign,
                            input bit last, input bit sel_off);
        is_msb = ms; is_skip_zero = sz;
        sum_act = sumv[SAW-1:0]; column_idx = col[CW-1:0]; mul_const = mulc[2:0];
        is_shift_mul = shm; hamming_sel = hsel[SW-1:0]; hamming_sign = hsign;
        for (int i = 0; i < NS; i++) act_sel[i] = sel_off ? SW'(8) : SW'(i);
        in_last = last; in_valid = 1'b1;
    endtask

    // Called at a falling edge with the beat already presented.
    task automatic push();
        int n = 0;
        #1;
        while (!ih.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (ih.in_ready !== 1'b1) begin
            errors++; $display("FAIL push_accept: in_ready=%0b required 1 after %0d cycles", ih.in_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int c = 0;
        while ((q_res.size() < n || q14_res.size() < n) && c < 100) begin
            @(negedge clk); c++;
        end
        checks++;
        if (q_res.size() < n || q14_res.size() < n) begin
            errors++; $display("FAIL wait_results: got %0d/%0d required %0d", q_res.size(), q14_res.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        set_act(1'b0);
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ih.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", ih.out_valid); end
        checks++; if (ih.result !== '0) begin errors++; $display("FAIL rst_result: got %0d required 0", ih.result); end
        checks++; if (ih.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b required 0", ih.overflow); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (ih.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b required 1", ih.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_base_term();
        clear_q();
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (ih.in_ready !== 1'b1) begin errors++; $display("FAIL base_in_ready: got %0b required 1", ih.in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ih.out_valid !== 1'b0) begin errors++; $display("FAIL base_early_valid: got %0b required 0", ih.out_valid); end
        @(negedge clk);
        checks++; if (ih.out_valid !== 1'b1) begin errors++; $display("FAIL base_valid: got %0b required 1", ih.out_valid); end
        checks++; if (ih.result !== 40) begin errors++; $display("FAIL base_result: got %0d required 40", ih.result); end
        wait_q(1);
        checks++; if (ovf_at(0) !== 0) begin errors++; $display("FAIL base_overflow: got %0d required 0", ovf_at(0)); end
    endtask

    task automatic test_two_column();
        clear_q();
        set_beat(1'b0, 1'b0, 36, 0, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b1, 1'b1, 36, 7, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        wait_q(1);
        checks++; if (res_at(0) !== -1254) begin errors++; $display("FAIL two_col: got %0d required -1254", res_at(0)); end
        checks++; if (res14_at(0) !== -1254) begin errors++; $display("FAIL two_col14: got %0d required -1254", res14_at(0)); end
    endtask

    task automatic test_special_term();
        clear_q();
        set_beat(1'b0, 1'b1, 36, 1, 3, 1'b1, 7, 1'b1, 1'b1, 1'b1); push();
        wait_q(1);
        checks++; if (res_at(0) !== 848) begin errors++; $display("FAIL special: got %0d required 848", res_at(0)); end
        checks++; if (res14_at(0) !== 848) begin errors++; $display("FAIL special14: got %0d required 848", res14_at(0)); end
    endtask

    task automatic test_backpressure();
        clear_q();
        out_ready = 1'b0;
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 1, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (ih.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: in_ready=%0b required 0", ih.in_ready); end
        checks++; if (ih.result !== 10) begin errors++; $display("FAIL bp_first: got %0d required 10", ih.result); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ih.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_hold: in_ready=%0b required 0", ih.in_ready); end
        checks++; if (ih.result !== 10 || ih.out_valid !== 1'b1) begin errors++; $display("FAIL bp_held: got %0d/%0b required 10/1", ih.result, ih.out_valid); end
        out_ready = 1'b1;
        push();
        wait_q(3);
        checks++; if (res_at(0) !== 10) begin errors++; $display("FAIL bp_order0: got %0d required 10", res_at(0)); end
        checks++; if (res_at(1) !== 20) begin errors++; $display("FAIL bp_order1: got %0d required 20", res_at(1)); end
        checks++; if (res_at(2) !== 40) begin errors++; $display("FAIL bp_order2: got %0d required 40", res_at(2)); end
        repeat (3) @(negedge clk);
        checks++; if (q_res.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d required 3", q_res.size()); end
    endtask

    task automatic test_accum_while_valid();
        clear_q();
        out_ready = 1'b0;
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 0, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        #1;
        checks++; if (ih.in_ready !== 1'b0) begin errors++; $display("FAIL acc_stall: in_ready=%0b required 0", ih.in_ready); end
        checks++; if (ih.result !== 10) begin errors++; $display("FAIL acc_held: got %0d required 10", ih.result); end
        @(negedge clk);
        out_ready = 1'b1;
        wait_q(2);
        checks++; if (res_at(0) !== 10) begin errors++; $display("FAIL acc_first: got %0d required 10", res_at(0)); end
        checks++; if (res_at(1) !== 30) begin errors++; $display("FAIL acc_second: got %0d required 30", res_at(1)); end
    endtask

    task automatic test_overflow();
        clear_q();
        set_act(1'b1);
        set_beat(1'b0, 1'b1, 0, 3, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 3, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 3, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        wait_q(1);
        checks++; if (res14_at(0) !== -4192) begin errors++; $display("FAIL ovf_result14: got %0d required -4192", res14_at(0)); end
        checks++; if (ovf14_at(0) !== 1) begin errors++; $display("FAIL ovf_flag14: got %0d required 1", ovf14_at(0)); end
        checks++; if (res_at(0) !== 12192) begin errors++; $display("FAIL ovf_result25: got %0d required 12192", res_at(0)); end
        checks++; if (ovf_at(0) !== 0) begin errors++; $display("FAIL ovf_flag25: got %0d required 0", ovf_at(0)); end
        clear_q();
        set_act(1'b0);
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        wait_q(1);
        checks++; if (res14_at(0) !== 40) begin errors++; $display("FAIL ovf_next_result: got %0d required 40", res14_at(0)); end
        checks++; if (ovf14_at(0) !== 0) begin errors++; $display("FAIL ovf_next_flag: got %0d required 0", ovf14_at(0)); end
    endtask

    task automatic test_reset_mid_group();
        clear_q();
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b0, 1'b0); push();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ih.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b required 0", ih.out_valid); end
        reset = 1'b1;
        @(negedge clk);
        set_beat(1'b0, 1'b1, 0, 2, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0); push();
        wait_q(1);
        repeat (3) @(negedge clk);
        checks++; if (res_at(0) !== 40) begin errors++; $display("FAIL mid_rst_result: got %0d required 40", res_at(0)); end
        checks++; if (q_res.size() !== 1) begin errors++; $display("FAIL mid_rst_count: got %0d required 1", q_res.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_base_term();
        test_two_column();
        test_special_term();
        test_backpressure();
        test_accum_while_valid();
        test_overflow();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
